sprite_line_select: RTL and testbench

- Per-scanline sprite evaluator in the GPU sprite path.
- On each line_start it walks the sprite attribute RAM (entries 0..NUM_SPRITES-1) and tests each enabled sprite against the requested scan line.
- For each sprite that hits, it emits one record downstream to the tile fetcher: index, x, tile row, pixel row and visible column range.
- It stops after MAX_PER_LINE hits and flags overflow.

---
 rtl/gpu_pkg.sv | 32 +++
 rtl/sprite_eval.sv | 74 +++++++
 rtl/sprite_line_select.sv | 161 ++++++++++++++++
 tb/tb_sprite_line_select.sv | 444 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Shared definitions for the sprite path: screen geometry, attribute word
// layout and the per-line evaluator state encoding.
package gpu_pkg;

  localparam int SCREEN_W = 640;

  // Attribute RAM word layout
  localparam int ATTR_W        = 44;
  localparam int ATTR_EN       = 43;
  localparam int ATTR_TILEY_HI = 42;
  localparam int ATTR_TILEY_LO = 39;
  localparam int ATTR_VFLIP    = 38;
  localparam int ATTR_SIZEY_HI = 37;
  localparam int ATTR_SIZEY_LO = 35;
  localparam int ATTR_SIZEX_HI = 34;
  localparam int ATTR_SIZEX_LO = 32;
  localparam int ATTR_Y_HI     = 31;
  localparam int ATTR_Y_LO     = 16;
  localparam int ATTR_X_HI     = 15;
  localparam int ATTR_X_LO     = 0;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_WAIT   = 3'd2,
    S_EVAL   = 3'd3,
    S_EMIT   = 3'd4,
    S_NEXT   = 3'd5,
    S_FINISH = 3'd6
  } state_t;

endpackage

// File: rtl/sprite_eval.sv
// Combinational hit test and record-field computation for one sprite
// attribute word against the current scan line. All arithmetic is 16-bit;
// x compares are signed, y compares unsigned.
module sprite_eval
  import gpu_pkg::*;
(
  input  logic [ATTR_W-1:0] attr,
  input  logic [9:0]        line_y,
  output logic              hit,
  output logic [2:0]        row,
  output logic [3:0]        tile_y,
  output logic [2:0]        first,
  output logic [2:0]        last
);

  logic        en;
  logic        vflip;
  logic [3:0]  tile_base;
  logic [2:0]  size_x;
  logic [2:0]  size_y;
  logic [15:0] y;
  logic [15:0] x;
  logic [15:0] ly;
  logic [15:0] w;
  logic [15:0] h;
  logic [15:0] y_end;
  logic [15:0] x_end;
  logic [15:0] neg_x;
  logic [15:0] room;
  logic        y_hit;
  logic        x_hit;
  logic [6:0]  r;
  logic [6:0]  n;

  // Decode the word, test coverage of the line and derive the row / clip info.
  always_comb begin
    en        = attr[ATTR_EN];
    vflip     = attr[ATTR_VFLIP];
    tile_base = attr[ATTR_TILEY_HI:ATTR_TILEY_LO];
    size_x    = attr[ATTR_SIZEX_HI:ATTR_SIZEX_LO];
    size_y    = attr[ATTR_SIZEY_HI:ATTR_SIZEY_LO];
    y         = attr[ATTR_Y_HI:ATTR_Y_LO];
    x         = attr[ATTR_X_HI:ATTR_X_LO];
    ly        = {6'd0, line_y};

    // 8*(size+1)-1 is just the size with three low ones appended
    w     = {10'd0, size_x, 3'b111};
    h     = {10'd0, size_y, 3'b111};
    y_end = y + h;
    x_end = x + w;

    y_hit = (ly >= y) && (ly <= y_end);
    x_hit = !x_end[15] && ($signed(x) < $signed(16'(SCREEN_W)));
    hit   = en && y_hit && x_hit;

    r = 7'(ly - y);
    n = vflip ? 7'(h[6:0] - r) : r;

    row    = n[2:0];
    tile_y = tile_base + n[6:3];

    // Columns hidden off the left edge; only meaningful when the sprite hits
    neg_x = 16'd0 - x;
    first = x[15] ? neg_x[5:3] : 3'd0;

    // Last tile column still left of the right edge, capped at the sprite width
    room = 16'(SCREEN_W - 1) - x;
    if (!room[15] && (room[15:3] < {10'd0, size_x}))
      last = room[5:3];
    else
      last = size_x;
  end

endmodule

// File: rtl/sprite_line_select.sv
// Per-scanline sprite selector: walks the attribute RAM in index order on
// each line_start, emits one record per hitting sprite (up to MAX_PER_LINE)
// and flags overflow when a further sprite would have hit.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   S_IDLE   | waiting for line_start
//   S_READ   | attr_rd strobe for entry idx
//   S_WAIT   | RAM data valid this cycle; captured into attr_q
//   S_EVAL   | hit test on attr_q; choose emit / overflow / skip
//   S_EMIT   | record held on out_* until out_ready
//   S_NEXT   | advance idx or finish the walk
//   S_FINISH | one-cycle done pulse
module sprite_line_select
  import gpu_pkg::*;
#(
  parameter int NUM_SPRITES  = 64,
  parameter int MAX_PER_LINE = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           line_start,
  input  logic [9:0]                     line_y,
  output logic [$clog2(NUM_SPRITES)-1:0] attr_addr,
  output logic                           attr_rd,
  input  logic [ATTR_W-1:0]              attr_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [$clog2(NUM_SPRITES)-1:0] out_index,
  output logic [15:0]                    out_x,
  output logic [3:0]                     out_tile_y,
  output logic [2:0]                     out_row,
  output logic [2:0]                     out_first,
  output logic [2:0]                     out_last,
  output logic                           busy,
  output logic                           done,
  output logic                           overflow
);

  localparam int AW = $clog2(NUM_SPRITES);
  localparam int CW = $clog2(MAX_PER_LINE + 1);
  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_SPRITES - 1);
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_PER_LINE);

  state_t state;
  state_t state_nxt;

  logic [AW-1:0]     idx;
  logic [CW-1:0]     count;
  logic [9:0]        line_q;
  logic [ATTR_W-1:0] attr_q;
  logic              room_left;

  logic              ev_hit;
  logic [2:0]        ev_row;
  logic [3:0]        ev_tile_y;
  logic [2:0]        ev_first;
  logic [2:0]        ev_last;

  logic [AW-1:0]     rec_index;
  logic [15:0]       rec_x;
  logic [3:0]        rec_tile_y;
  logic [2:0]        rec_row;
  logic [2:0]        rec_first;
  logic [2:0]        rec_last;

  sprite_eval u_eval (
    .attr   (attr_q),
    .line_y (line_q),
    .hit    (ev_hit),
    .row    (ev_row),
    .tile_y (ev_tile_y),
    .first  (ev_first),
    .last   (ev_last)
  );

  assign room_left = (count != MAX_CNT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state; a line_start from any state restarts the walk (abort when busy).
  always_comb begin
    state_nxt = state;
    if (line_start) begin
      state_nxt = S_READ;
    end else begin
      case (state)
        S_IDLE:   state_nxt = S_IDLE;
        S_READ:   state_nxt = S_WAIT;
        S_WAIT:   state_nxt = S_EVAL;
        S_EVAL: begin
          if (ev_hit && room_left) state_nxt = S_EMIT;
          else if (ev_hit)         state_nxt = S_FINISH;
          else                     state_nxt = S_NEXT;
        end
        S_EMIT:   if (out_ready) state_nxt = S_NEXT;
        S_NEXT:   state_nxt = (idx == LAST_IDX) ? S_FINISH : S_READ;
        S_FINISH: state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // Walk datapath: line latch, index / hit counters, attribute capture, record.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= '0;
      count      <= '0;
      line_q     <= '0;
      attr_q     <= '0;
      overflow   <= 1'b0;
      rec_index  <= '0;
      rec_x      <= '0;
      rec_tile_y <= '0;
      rec_row    <= '0;
      rec_first  <= '0;
      rec_last   <= '0;
    end else if (line_start) begin
      line_q   <= line_y;
      idx      <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_WAIT: attr_q <= attr_data;
        S_EVAL: begin
          if (ev_hit && room_left) begin
            rec_index  <= idx;
            rec_x      <= attr_q[ATTR_X_HI:ATTR_X_LO];
            rec_tile_y <= ev_tile_y;
            rec_row    <= ev_row;
            rec_first  <= ev_first;
            rec_last   <= ev_last;
          end else if (ev_hit) begin
            overflow <= 1'b1;
          end
        end
        S_EMIT: if (out_ready) count <= count + 1'b1;
        S_NEXT: if (idx != LAST_IDX) idx <= idx + 1'b1;
        default: ;
      endcase
    end
  end

  assign attr_addr  = idx;
  assign attr_rd    = (state == S_READ);
  assign out_valid  = (state == S_EMIT);
  assign busy       = (state != S_IDLE);
  assign done       = (state == S_FINISH);
  assign out_index  = rec_index;
  assign out_x      = rec_x;
  assign out_tile_y = rec_tile_y;
  assign out_row    = rec_row;
  assign out_first  = rec_first;
  assign out_last   = rec_last;

endmodule

// File: tb/tb_sprite_line_select.sv
// Bench for sprite_line_select: behavioural RAM plus a per-line reference
// model computed straight from the sprite geometry rules.
module tb_sprite_line_select;

  localparam int NUM  = 64;
  localparam int MAXL = 8;

  typedef struct packed {
    int index;
    int x;
    int tile_y;
    int row;
    int first;
    int last;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        line_start;
  logic [9:0]  line_y;
  logic [5:0]  attr_addr;
  logic        attr_rd;
  logic [43:0] attr_data;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_index;
  logic [15:0] out_x;
  logic [3:0]  out_tile_y;
  logic [2:0]  out_row;
  logic [2:0]  out_first;
  logic [2:0]  out_last;
  logic        busy;
  logic        done;
  logic        overflow;

  logic [43:0] mem [NUM];
  rec_t        exp_q[$];
  rec_t        got_q[$];
  bit          exp_ovf;
  int          ninth;
  int          errors = 0;
  int          checks = 0;

  sprite_line_select #(.NUM_SPRITES(NUM), .MAX_PER_LINE(MAXL)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_start (line_start),
    .line_y     (line_y),
    .attr_addr  (attr_addr),
    .attr_rd    (attr_rd),
    .attr_data  (attr_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_index  (out_index),
    .out_x      (out_x),
    .out_tile_y (out_tile_y),
    .out_row    (out_row),
    .out_first  (out_first),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  // RAM: data valid only in the cycle after the strobe, junk otherwise
  always @(posedge clk)
    attr_data <= attr_rd ? mem[attr_addr] : 44'({$urandom, $urandom});

  function automatic logic [43:0] mk(bit en, int ty, bit vf, int sy, int sx, int y, int x);
    logic [43:0] a;
    a[43]    = en;
    a[42:39] = 4'(ty);
    a[38]    = vf;
    a[37:35] = 3'(sy);
    a[34:32] = 3'(sx);
    a[31:16] = 16'(y);
    a[15:0]  = 16'(x);
    return a;
  endfunction

  function automatic rec_t cur_rec();
    rec_t rc;
    rc.index  = int'(out_index);
    rc.x      = int'($signed(out_x));
    rc.tile_y = int'(out_tile_y);
    rc.row    = int'(out_row);
    rc.first  = int'(out_first);
    rc.last   = int'(out_last);
    return rc;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < NUM; i++) mem[i] = 44'd0;
  endtask

  // Reference: which sprites land on line ly, in index order, with their fields
  task automatic model_line(input int ly);
    int nh;
    exp_q.delete();
    exp_ovf = 0;
    ninth   = -1;
    nh      = 0;
    for (int i = 0; i < NUM; i++) begin
      logic [43:0] e;
      int ty, sy, sx, y, x, w, h, yend, xr, r, n, room;
      bit en, vf, hit;
      rec_t rc;
      e  = mem[i];
      en = e[43];
      ty = int'(e[42:39]);
      vf = e[38];
      sy = int'(e[37:35]);
      sx = int'(e[34:32]);
      y  = int'(e[31:16]);
      x  = int'($signed(e[15:0]));
      w  = 8 * (sx + 1) - 1;
      h  = 8 * (sy + 1) - 1;
      yend = (y + h) % 65536;
      xr = x + w;
      if (xr > 32767) xr -= 65536;
      hit = en && (ly >= y) && (ly <= yend) && (xr >= 0) && (x < 640);
      if (!hit) continue;
      nh++;
      if (nh > MAXL) begin
        exp_ovf = 1;
        ninth   = i;
        break;
      end
      r = (ly - y) % 128;
      n = vf ? (h - r) % 128 : r;
      room = (639 - x) / 8;
      rc.index  = i;
      rc.x      = x;
      rc.row    = n % 8;
      rc.tile_y = (ty + n / 8) % 16;
      rc.first  = (x < 0) ? ((-x) / 8) % 8 : 0;
      rc.last   = (room < sx) ? room : sx;
      exp_q.push_back(rc);
    end
  endtask

  // Run one full line (starting it, or aborting one in flight) and check it
  task automatic do_line(input int ly, input bit rnd_ready, input string tag);
    int cyc;
    int exp_cyc;
    bit seen_done;
    model_line(ly);
    got_q.delete();
    @(negedge clk);
    line_y     = 10'(ly);
    line_start = 1'b1;
    out_ready  = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    cyc        = 1;
    seen_done  = 0;
    checks++;
    if (busy !== 1'b1 || attr_rd !== 1'b1 || attr_addr !== 6'd0) begin
      errors++;
      $display("FAIL %s first_read: busy=%b rd=%b addr=%0d required 1 1 0", tag, busy, attr_rd, attr_addr);
    end
    while (cyc < 4000) begin
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid === 1'b1 && out_ready) got_q.push_back(cur_rec());
      if (done === 1'b1) begin
        seen_done = 1;
        break;
      end
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (!seen_done) begin
      errors++;
      $display("FAIL %s done_timeout: no done within %0d cycles", tag, cyc);
    end
    if (!rnd_ready && seen_done) begin
      exp_cyc = exp_ovf ? 4 * ninth + exp_q.size() + 4 : 4 * NUM + exp_q.size() + 1;
      checks++;
      if (cyc != exp_cyc) begin
        errors++;
        $display("FAIL %s done_cycle: got %0d required %0d", tag, cyc, exp_cyc);
      end
    end
    checks++;
    if (overflow !== exp_ovf) begin
      errors++;
      $display("FAIL %s overflow: got %b required %b", tag, overflow, exp_ovf);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s record_count: got %0d required %0d", tag, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] != exp_q[i]) begin
        errors++;
        $display("FAIL %s record[%0d]: got idx=%0d x=%0d ty=%0d row=%0d f=%0d l=%0d required idx=%0d x=%0d ty=%0d row=%0d f=%0d l=%0d",
                 tag, i, got_q[i].index, got_q[i].x, got_q[i].tile_y, got_q[i].row, got_q[i].first, got_q[i].last,
                 exp_q[i].index, exp_q[i].x, exp_q[i].tile_y, exp_q[i].row, exp_q[i].first, exp_q[i].last);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s after_done: done=%b busy=%b required 0 0", tag, done, busy);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: busy=%b done=%b valid=%b ovf=%b required all 0", busy, done, out_valid, overflow);
    end
    checks++;
    if (attr_rd !== 1'b0 || attr_addr !== 6'd0) begin
      errors++;
      $display("FAIL reset_ram: rd=%b addr=%0d required 0 0", attr_rd, attr_addr);
    end
    checks++;
    if (out_index !== 6'd0 || out_x !== 16'd0 || out_tile_y !== 4'd0 ||
        out_row !== 3'd0 || out_first !== 3'd0 || out_last !== 3'd0) begin
      errors++;
      $display("FAIL reset_record: idx=%0d x=%0d ty=%0d row=%0d f=%0d l=%0d required all 0",
               out_index, out_x, out_tile_y, out_row, out_first, out_last);
    end
  endtask

  task automatic test_single();
    rec_t want;
    clear_mem();
    mem[3] = mk(1, 2, 0, 1, 1, 50, 100);
    do_line(60, 0, "single");
    want = '{index: 3, x: 100, tile_y: 3, row: 2, first: 0, last: 1};
    checks++;
    if (got_q.size() != 1 || got_q[0] != want) begin
      errors++;
      $display("FAIL single_fixed: got %0d records (first row=%0d ty=%0d) required 1 record row=2 ty=3",
               got_q.size(), got_q.size() ? got_q[0].row : -1, got_q.size() ? got_q[0].tile_y : -1);
    end
  endtask

  task automatic test_vflip();
    clear_mem();
    mem[3] = mk(1, 2, 1, 1, 1, 50, 100);
    do_line(60, 0, "vflip");
    checks++;
    if (got_q.size() != 1 || got_q[0].row != 5 || got_q[0].tile_y != 2) begin
      errors++;
      $display("FAIL vflip_fixed: got %0d records (row=%0d ty=%0d) required 1 record row=5 ty=2",
               got_q.size(), got_q.size() ? got_q[0].row : -1, got_q.size() ? got_q[0].tile_y : -1);
    end
  endtask

  task automatic test_clipping();
    clear_mem();
    mem[5] = mk(1, 0, 0, 0, 3, 0, -12);
    do_line(0, 0, "clip_left");
    checks++;
    if (got_q.size() != 1 || got_q[0].first != 1 || got_q[0].last != 3) begin
      errors++;
      $display("FAIL clip_left: got %0d records (f=%0d l=%0d) required 1 record f=1 l=3",
               got_q.size(), got_q.size() ? got_q[0].first : -1, got_q.size() ? got_q[0].last : -1);
    end
    mem[5] = mk(1, 0, 0, 0, 3, 0, 630);
    do_line(0, 0, "clip_right");
    checks++;
    if (got_q.size() != 1 || got_q[0].first != 0 || got_q[0].last != 1) begin
      errors++;
      $display("FAIL clip_right: got %0d records (f=%0d l=%0d) required 1 record f=0 l=1",
               got_q.size(), got_q.size() ? got_q[0].first : -1, got_q.size() ? got_q[0].last : -1);
    end
    mem[5] = mk(1, 0, 0, 0, 7, 0, -64);
    do_line(0, 0, "clip_gone");
    checks++;
    if (got_q.size() != 0) begin
      errors++;
      $display("FAIL clip_gone: got %0d records required 0", got_q.size());
    end
  endtask

  task automatic test_overflow();
    clear_mem();
    for (int i = 0; i < 10; i++) mem[i] = mk(1, i, 0, 0, 0, 0, 8 * i);
    do_line(0, 0, "overflow");
    checks++;
    if (got_q.size() != 8 || got_q[0].index != 0 || got_q[got_q.size() - 1].index != 7) begin
      errors++;
      $display("FAIL overflow_fixed: got %0d records required 8 with indices 0..7", got_q.size());
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_sticky: got %b required 1", overflow);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      int ly;
      bit dense;
      ly    = $urandom_range(0, 479);
      dense = (t % 2) == 1;
      for (int i = 0; i < NUM; i++) begin
        int y, x;
        x = int'($urandom_range(0, 800)) - 90;
        y = dense ? (ly + 65536 - int'($urandom_range(0, 70))) % 65536 : int'($urandom_range(0, 1023));
        mem[i] = mk(dense ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 1) == 1),
                    $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 7),
                    $urandom_range(0, 7), y, x);
      end
      do_line(ly, t >= 4, "random");
    end
  endtask

  task automatic test_backpressure();
    rec_t want;
    int cyc;
    int acc;
    clear_mem();
    mem[10] = mk(1, 14, 0, 2, 2, 60, -20);
    model_line(70);
    want = exp_q[0];
    @(negedge clk);
    line_y = 10'd70;
    line_start = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    line_start = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_valid_timeout: out_valid=%b after %0d cycles required 1", out_valid, cyc);
    end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (out_valid !== 1'b1 || cur_rec() != want) begin
        errors++;
        $display("FAIL bp_stable[%0d]: valid=%b idx=%0d row=%0d ty=%0d required valid=1 idx=%0d row=%0d ty=%0d",
                 i, out_valid, out_index, out_row, out_tile_y, want.index, want.row, want.tile_y);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    acc = 0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 400) begin
      if (out_valid === 1'b1) acc++;
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (acc != 1 || done !== 1'b1) begin
      errors++;
      $display("FAIL bp_accept: accepted %0d done=%b required 1 1", acc, done);
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int ndone;
    clear_mem();
    for (int i = 0; i < 4; i++) mem[i] = mk(1, 1, 0, 0, 0, 100, 16 * i);
    mem[40] = mk(1, 2, 0, 0, 1, 96, 300);
    mem[5]  = mk(1, 3, 0, 1, 2, 190, 50);
    mem[20] = mk(1, 4, 1, 0, 0, 200, 600);
    @(negedge clk);
    line_y = 10'd100;
    line_start = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    ndone = 0;
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    checks++;
    if (ndone != 0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: done pulses %0d busy=%b required 0 1", ndone, busy);
    end
    do_line(200, 0, "abort");
  endtask

  task automatic test_reset_mid_emit();
    int cyc;
    clear_mem();
    mem[7] = mk(1, 5, 0, 0, 0, 30, 200);
    @(negedge clk);
    line_y = 10'd30;
    line_start = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    line_start = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_index !== 6'd0) begin
      errors++;
      $display("FAIL reset_mid_emit: valid=%b busy=%b idx=%0d required 0 0 0", out_valid, busy, out_index);
    end
    @(negedge clk);
    rst_n = 1'b1;
    do_line(30, 0, "post_reset");
  endtask

  initial begin
    rst_n      = 1'b0;
    line_start = 1'b0;
    line_y     = 10'd0;
    out_ready  = 1'b0;
    clear_mem();
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    test_single();
    test_vflip();
    test_clipping();
    test_overflow();
    test_random();
    test_backpressure();
    test_abort();
    test_reset_mid_emit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
